mem_bus_responder: RTL and testbench
====================================

# mem_bus_responder

Responder end of the byte-wide memory bus driven by the CPU's memory adapter. It decodes each cycle's address/write strobe, serves a synchronous byte RAM with one-cycle read latency, and maps the top address region onto a UART byte port with a TX FIFO. It generates the `io_buffer_full` back-pressure and the simulation-halt flag. It sits at the top level between the core and the RAM/UART, so the core and its adapter can run unmodified against it.

## Interface
Parameters:
- `RAM_ADDR_WIDTH`, 17: RAM depth is 2^17 bytes, byte-addressed by `bus_a[16:0]`.
- `TX_FIFO_DEPTH`, 8: UART TX FIFO depth in bytes; power of two, at least 4.

Ports:
- `clk_in` input 1: system clock; all state changes on the rising edge.
- `rst_in` input 1: asynchronous, active-low reset.
- `rdy_in` input 1: when low, the block freezes; no state change.
- `bus_a` input 32: byte address from the initiator; bits 31:18 are ignored.
- `bus_wr` input 1: 1 = write this cycle, 0 = read.
- `bus_din` input 8: write data from the initiator.
- `bus_dout` output 8: read data returned to the initiator, registered.
- `io_buffer_full` output 1: TX FIFO near-full back-pressure, registered.
- `uart_tx_data` output 8: head byte of the TX FIFO.
- `uart_tx_valid` output 1: TX FIFO non-empty.
- `uart_tx_ready` input 1: UART accepts the head byte this cycle.
- `uart_rx_data` input 8: received byte offered by the UART.
- `uart_rx_valid` input 1: `uart_rx_data` is valid.
- `uart_rx_ready` output 1: combinational; pulses for one cycle when a read of the RX data port consumes the offered byte.
- `sim_halt` output 1: sticky; set by a write to the halt port.
- `tx_overflow` output 1: sticky; set by a write to a full TX FIFO.

## Operation
- Decode per cycle, qualified by `rdy_in` = 1:
  - IO when `bus_a[17:16]` = 2'b11; otherwise RAM at `bus_a[16:0]`.
- RAM write (`bus_wr` = 1): `bus_din` is stored at the address on the same clock edge.
- RAM read: the byte appears on `bus_dout` after the next edge. A read of an address in the same cycle as a write to it returns the old byte.
- IO address 0x30000:
  - Write pushes `bus_din` into the TX FIFO.
  - Read returns `uart_rx_data` if `uart_rx_valid`, else 0x00. If `uart_rx_valid` is high, the read asserts `uart_rx_ready` for that cycle.
- IO address 0x30004:
  - Write sets `sim_halt`.
  - Read returns {6'b0, `uart_rx_valid`, `io_buffer_full`}.
- Other IO addresses: reads return 0x00, writes are ignored.
- TX FIFO:
  - Pop when `uart_tx_valid` and `uart_tx_ready`.
  - Count is `$clog2(DEPTH)+1` bits.
  - Simultaneous push and pop: count unchanged and data order preserved, including push and pop at the same pointer index.
  - Read and write pointers wrap modulo DEPTH.
- Push when count = DEPTH: the byte is dropped and `tx_overflow` is set (sticky until reset).
- `io_buffer_full` is registered. It is 1 when the next-state count ≥ DEPTH-1, so one slot stays in reserve for a write already in flight when the initiator samples the flag.
- The `bus_dout` source is chosen by a registered select bit (IO vs RAM) captured with the address.
- `rdy_in` = 0: RAM not written, FIFOs/flags unchanged, `bus_dout` holds, `uart_rx_ready` = 0. The UART pop also stalls.

## Timing
- Read latency is exactly 1 cycle: address A presented at edge N produces data(A) on `bus_dout` after edge N+1. Back-to-back reads stream one byte per cycle.
- Write latency: the value is visible to a read issued one cycle later.
- A TX push at edge N gives `uart_tx_valid` = 1 after edge N; the UART may pop at the same edge as the next push.
- `io_buffer_full` rises in the cycle after the push that makes count reach DEPTH-1. It falls in the cycle after a pop takes count below DEPTH-1.
- Reset (asynchronous assert, any time including mid-burst), all outputs forced immediately:
  - `bus_dout` = 0x00, `io_buffer_full` = 0, `uart_tx_valid` = 0, `sim_halt` = 0, `tx_overflow` = 0.
  - FIFO emptied.
  - RAM contents are not cleared.
- Deassertion is taken synchronously at the next edge.

## Test plan
- RAM write/read: write 0xA5 to 0x00010 and 0x3C to 0x1FFFF, then read both back-to-back → 0xA5 one cycle after the first read address, 0x3C the cycle after.
- Read-during-write: write 0x11 to 0x00020 while reading 0x00020 in the same cycle → the read returns the old byte; a read one cycle later returns 0x11.
- TX FIFO full, DEPTH = 8, `uart_tx_ready` = 0:
  - Push 7 bytes → `io_buffer_full` = 1 on the cycle after the 7th push.
  - 8th push is accepted.
  - 9th push → `tx_overflow` = 1; bytes drain in order 1..8 once ready = 1.
- Simultaneous push/pop at count 3 → count stays 3, `io_buffer_full` stays 0, output order intact.
- IO reads:
  - `uart_rx_valid` = 1 with data 0x42 → read 0x30000 returns 0x42 with `uart_rx_ready` pulsed for 1 cycle.
  - Read 0x30004 → 0x02 | full bit.
  - Write 0x30004 → `sim_halt` = 1 and stays set.
- `rdy_in` low for 3 cycles mid-stream, then `rst_in` asserted mid-burst → no RAM/FIFO change while rdy_in is low; all outputs go to reset values immediately on reset.

Source files
------------

// File: rtl/mem_bus_responder.sv
// ---------------------------------------------------------------------------
// mem_bus_responder
//
// Responder end of the byte-wide memory bus driven by the CPU's memory
// adapter. Each cycle's address is decoded into either a synchronous byte RAM
// (one-cycle read latency) or the IO region (bus_a[17:16] == 2'b11), which
// holds a UART data port with a TX FIFO and a status/halt port.
//
// Ports:
//   clk_in          system clock, all state changes on the rising edge
//   rst_in          asynchronous active-low reset
//   rdy_in          global enable; when low nothing changes state
//   bus_a           byte address (bits 31:18 ignored)
//   bus_wr          1 = write cycle, 0 = read cycle
//   bus_din         write data
//   bus_dout        registered read data
//   io_buffer_full  registered TX FIFO near-full back-pressure
//   uart_tx_data    head byte of the TX FIFO
//   uart_tx_valid   TX FIFO non-empty
//   uart_tx_ready   UART accepts the head byte this cycle
//   uart_rx_data    received byte offered by the UART
//   uart_rx_valid   uart_rx_data is valid
//   uart_rx_ready   combinational consume strobe for the offered RX byte
//   sim_halt        sticky, set by a write to the halt port
//   tx_overflow     sticky, set by a write to a full TX FIFO
// ---------------------------------------------------------------------------
module mem_bus_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_DEPTH  = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] bus_a,
    input  logic        bus_wr,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic        io_buffer_full,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic        sim_halt,
    output logic        tx_overflow
);

    localparam int PTR_W     = $clog2(TX_FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

    localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(TX_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_MARK    = CNT_W'(TX_FIFO_DEPTH - 1);
    localparam logic [17:0]      IO_DATA_ADDR = 18'h30000;
    localparam logic [17:0]      IO_STAT_ADDR = 18'h30004;

    logic                      is_io;
    logic                      io_data_hit;
    logic                      io_stat_hit;
    logic                      ram_we;
    logic                      tx_push_req;
    logic                      tx_push;
    logic                      tx_pop;
    logic                      halt_set;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]                io_rdata;

    logic [CNT_W-1:0]          tx_count;
    logic [CNT_W-1:0]          tx_count_next;
    logic [PTR_W-1:0]          tx_rd_ptr;
    logic [PTR_W-1:0]          tx_wr_ptr;
    logic [7:0]                tx_mem [TX_FIFO_DEPTH];

    logic [7:0]                ram [RAM_DEPTH];
    logic [7:0]                ram_q;
    logic                      io_sel_q;
    logic [7:0]                io_q;

    // The upper address bits carry no meaning for this responder.
    logic                      unused_addr_bits;
    assign unused_addr_bits = ^bus_a[31:18];

    assign ram_addr      = bus_a[RAM_ADDR_WIDTH-1:0];
    assign uart_tx_valid = (tx_count != '0);
    assign uart_tx_data  = tx_mem[tx_rd_ptr];

    // Read data comes from whichever source was selected when the address was
    // captured. Reset parks the select on the IO register (cleared to zero) so
    // bus_dout reads 0x00 immediately without having to reset the RAM output.
    assign bus_dout = io_sel_q ? io_q : ram_q;

    // Address decode and per-cycle strobes. Everything that changes state is
    // qualified by rdy_in so a stalled cycle has no side effects, including
    // the RX consume strobe and the TX pop toward the UART.
    always_comb begin
        is_io         = (bus_a[17:16] == 2'b11);
        io_data_hit   = (bus_a[17:0] == IO_DATA_ADDR);
        io_stat_hit   = (bus_a[17:0] == IO_STAT_ADDR);
        ram_we        = rdy_in && bus_wr && !is_io;
        tx_push_req   = rdy_in && bus_wr && io_data_hit;
        // A push is only taken while there is room; otherwise it is dropped
        // and reported through tx_overflow.
        tx_push       = tx_push_req && (tx_count != DEPTH_CNT);
        tx_pop        = rdy_in && uart_tx_valid && uart_tx_ready;
        halt_set      = rdy_in && bus_wr && io_stat_hit;
        uart_rx_ready = rdy_in && !bus_wr && io_data_hit && uart_rx_valid;

        io_rdata = 8'h00;
        if (!bus_wr) begin
            if (io_data_hit && uart_rx_valid) begin
                io_rdata = uart_rx_data;
            end else if (io_stat_hit) begin
                io_rdata = {6'b0, uart_rx_valid, io_buffer_full};
            end
        end

        // Push and pop together leave the occupancy unchanged.
        tx_count_next = tx_count;
        unique case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count + 1'b1;
            2'b01:   tx_count_next = tx_count - 1'b1;
            default: tx_count_next = tx_count;
        endcase
    end

    // Control state: FIFO pointers and count, back-pressure, sticky flags and
    // the IO half of the read path. io_buffer_full looks at the next-state
    // count so the flag the initiator samples already reflects this edge's
    // push, leaving one slot spare for a write already on its way.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_count       <= '0;
            tx_rd_ptr      <= '0;
            tx_wr_ptr      <= '0;
            io_buffer_full <= 1'b0;
            sim_halt       <= 1'b0;
            tx_overflow    <= 1'b0;
            io_sel_q       <= 1'b1;
            io_q           <= 8'h00;
        end else if (rdy_in) begin
            tx_count       <= tx_count_next;
            io_buffer_full <= (tx_count_next >= FULL_MARK);
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            if (halt_set) begin
                sim_halt <= 1'b1;
            end
            if (tx_push_req && !tx_push) begin
                tx_overflow <= 1'b1;
            end
            io_sel_q <= is_io;
            io_q     <= io_rdata;
        end
    end

    // TX FIFO storage. Pointers are PTR_W bits wide, so they wrap modulo the
    // power-of-two depth on their own. Contents need no reset: the count
    // alone decides what is valid.
    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= bus_din;
        end
    end

    // Byte RAM, read-first: the output register samples the array before the
    // write lands, so a write cycle returns the previous byte at that address
    // and the new byte is visible to a read issued one cycle later.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (ram_we) begin
                ram[ram_addr] <= bus_din;
            end
            ram_q <= ram[ram_addr];
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_responder
//
// Self-checking bench for mem_bus_responder. A behavioural model (sparse RAM
// map, byte queue for the TX FIFO, plain flags) predicts every output, and a
// directed prologue pins the model with hand-computed literal values before a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_mem_bus_responder;

    localparam int DEPTH = 8;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] bus_a;
    logic        bus_wr;
    logic [7:0]  bus_din;
    logic [7:0]  bus_dout;
    logic        io_buffer_full;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic        sim_halt;
    logic        tx_overflow;

    int checks;
    int errors;

    // Behavioural model state: what each output must be after the last edge.
    logic [7:0] model_ram [int];
    logic [7:0] model_q [$];
    logic [7:0] exp_dout;
    bit         dout_known;
    bit         exp_full;
    bit         exp_halt;
    bit         exp_ovf;
    logic       last_rx_ready;

    mem_bus_responder #(
        .RAM_ADDR_WIDTH(17),
        .TX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .bus_a         (bus_a),
        .bus_wr        (bus_wr),
        .bus_din       (bus_din),
        .bus_dout      (bus_dout),
        .io_buffer_full(io_buffer_full),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .sim_halt      (sim_halt),
        .tx_overflow   (tx_overflow)
    );

    // Free-running clock, period 10.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Hard time limit so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: every check goes through here.
    task automatic checkVal(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        exp_dout   = 8'h00;
        dout_known = 1'b1;
        exp_full   = 1'b0;
        exp_halt   = 1'b0;
        exp_ovf    = 1'b0;
    endtask

    function automatic logic expRxReady();
        return rdy_in && !bus_wr && (bus_a[17:0] == 18'h30000) && uart_rx_valid;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic modelStep();
        logic [17:0] a18;
        int          ra;
        int          pre;
        a18 = bus_a[17:0];
        if (rdy_in) begin
            if (a18[17:16] == 2'b11) begin
                dout_known = 1'b1;
                if (bus_wr)                   exp_dout = 8'h00;
                else if (a18 == 18'h30000)    exp_dout = uart_rx_valid ? uart_rx_data : 8'h00;
                else if (a18 == 18'h30004)    exp_dout = {6'b0, uart_rx_valid, exp_full};
                else                          exp_dout = 8'h00;
            end else begin
                ra = int'(bus_a[16:0]);
                if (model_ram.exists(ra)) begin
                    exp_dout   = model_ram[ra];
                    dout_known = 1'b1;
                end else begin
                    dout_known = 1'b0;
                end
                if (bus_wr) model_ram[ra] = bus_din;
            end
            pre = model_q.size();
            if (pre > 0 && uart_tx_ready) void'(model_q.pop_front());
            if (bus_wr && a18 == 18'h30000) begin
                if (pre < DEPTH) model_q.push_back(bus_din);
                else             exp_ovf = 1'b1;
            end
            if (bus_wr && a18 == 18'h30004) exp_halt = 1'b1;
            exp_full = (model_q.size() >= DEPTH - 1);
        end
    endtask

    // Compare all registered outputs against the model (called at negedge).
    task automatic checkOutput();
        if (dout_known) checkVal("bus_dout", bus_dout, exp_dout);
        checkVal("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, exp_full});
        checkVal("uart_tx_valid", {7'b0, uart_tx_valid}, {7'b0, (model_q.size() != 0)});
        if (model_q.size() != 0) checkVal("uart_tx_data", uart_tx_data, model_q[0]);
        checkVal("sim_halt", {7'b0, sim_halt}, {7'b0, exp_halt});
        checkVal("tx_overflow", {7'b0, tx_overflow}, {7'b0, exp_ovf});
    endtask

    // One bus cycle: drive at negedge, check the combinational RX strobe,
    // advance the model, then check all outputs at the following negedge.
    task automatic applyStimulus(input logic rdy, input logic [31:0] a, input logic wr,
                                 input logic [7:0] din, input logic txr,
                                 input logic [7:0] rxd, input logic rxv);
        rdy_in        = rdy;
        bus_a         = a;
        bus_wr        = wr;
        bus_din       = din;
        uart_tx_ready = txr;
        uart_rx_data  = rxd;
        uart_rx_valid = rxv;
        #1;
        last_rx_ready = uart_rx_ready;
        checkVal("uart_rx_ready", {7'b0, uart_rx_ready}, {7'b0, expRxReady()});
        modelStep();
        @(posedge clk_in);
        @(negedge clk_in);
        checkOutput();
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic resetMidCycle();
        #2 rst_in = 1'b0;
        #1;
        checkVal("rst_bus_dout", bus_dout, 8'h00);
        checkVal("rst_full", {7'b0, io_buffer_full}, 8'h00);
        checkVal("rst_tx_valid", {7'b0, uart_tx_valid}, 8'h00);
        checkVal("rst_halt", {7'b0, sim_halt}, 8'h00);
        checkVal("rst_ovf", {7'b0, tx_overflow}, 8'h00);
        modelReset();
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        checkOutput();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [16:0] ra;
        checks        = 0;
        errors        = 0;
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        bus_a         = 32'h0;
        bus_wr        = 1'b0;
        bus_din       = 8'h00;
        uart_tx_ready = 1'b0;
        uart_rx_data  = 8'h00;
        uart_rx_valid = 1'b0;
        modelReset();
        repeat (2) @(negedge clk_in);
        checkVal("init_bus_dout", bus_dout, 8'h00);
        checkVal("init_tx_valid", {7'b0, uart_tx_valid}, 8'h00);
        checkVal("init_full", {7'b0, io_buffer_full}, 8'h00);
        rst_in = 1'b1;
        checkOutput();

        // RAM write then back-to-back reads, including the top address.
        applyStimulus(1, 32'h0000_0010, 1, 8'hA5, 0, 8'h00, 0);
        applyStimulus(1, 32'h0001_FFFF, 1, 8'h3C, 0, 8'h00, 0);
        applyStimulus(1, 32'h0000_0010, 0, 8'h00, 0, 8'h00, 0);
        checkVal("ram_rd_a5", bus_dout, 8'hA5);
        applyStimulus(1, 32'h0001_FFFF, 0, 8'h00, 0, 8'h00, 0);
        checkVal("ram_rd_3c", bus_dout, 8'h3C);
        applyStimulus(1, 32'hFFFC_0010, 0, 8'h00, 0, 8'h00, 0);
        checkVal("ram_upper_bits_ignored", bus_dout, 8'hA5);

        // Read during write returns the old byte; the next read sees the new.
        applyStimulus(1, 32'h0000_0020, 1, 8'h77, 0, 8'h00, 0);
        applyStimulus(1, 32'h0000_0020, 1, 8'h11, 0, 8'h00, 0);
        checkVal("rdw_old", bus_dout, 8'h77);
        applyStimulus(1, 32'h0000_0020, 0, 8'h00, 0, 8'h00, 0);
        checkVal("rdw_new", bus_dout, 8'h11);

        // Fill the TX FIFO with the UART stalled.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1, 32'h0003_0000, 1, 8'(i), 0, 8'h00, 0);
            if (i == 6) checkVal("full_after_6", {7'b0, io_buffer_full}, 8'h00);
        end
        checkVal("full_after_7", {7'b0, io_buffer_full}, 8'h01);
        applyStimulus(1, 32'h0003_0004, 0, 8'h00, 0, 8'h00, 1);
        checkVal("status_full", bus_dout, 8'h03);
        applyStimulus(1, 32'h0003_0000, 1, 8'd8, 0, 8'h00, 0);
        checkVal("push8_no_ovf", {7'b0, tx_overflow}, 8'h00);
        applyStimulus(1, 32'h0003_0000, 1, 8'd9, 0, 8'h00, 0);
        checkVal("push9_ovf", {7'b0, tx_overflow}, 8'h01);
        for (int i = 1; i <= 8; i++) begin
            checkVal("drain_order", uart_tx_data, 8'(i));
            applyStimulus(1, 32'h0000_0010, 0, 8'h00, 1, 8'h00, 0);
        end
        checkVal("drained_valid", {7'b0, uart_tx_valid}, 8'h00);
        checkVal("drained_full", {7'b0, io_buffer_full}, 8'h00);

        // Simultaneous push and pop at occupancy 3.
        applyStimulus(1, 32'h0003_0000, 1, 8'hB0, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0000, 1, 8'hB1, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0000, 1, 8'hB2, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0000, 1, 8'hB3, 1, 8'h00, 0);
        checkVal("pushpop_head", uart_tx_data, 8'hB1);
        checkVal("pushpop_full", {7'b0, io_buffer_full}, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            checkVal("pushpop_order", uart_tx_data, 8'(8'hB0 + i));
            applyStimulus(1, 32'h0000_0010, 0, 8'h00, 1, 8'h00, 0);
        end
        checkVal("pushpop_empty", {7'b0, uart_tx_valid}, 8'h00);

        // IO reads and the halt port.
        applyStimulus(1, 32'h0003_0000, 0, 8'h00, 0, 8'h42, 1);
        checkVal("rx_ready_pulse", {7'b0, last_rx_ready}, 8'h01);
        checkVal("rx_data", bus_dout, 8'h42);
        applyStimulus(1, 32'h0003_0000, 0, 8'h00, 0, 8'h42, 0);
        checkVal("rx_ready_idle", {7'b0, last_rx_ready}, 8'h00);
        checkVal("rx_empty_data", bus_dout, 8'h00);
        applyStimulus(1, 32'h0003_0004, 0, 8'h00, 0, 8'h00, 1);
        checkVal("status_rx", bus_dout, 8'h02);
        applyStimulus(1, 32'h0003_0004, 1, 8'h00, 0, 8'h00, 0);
        checkVal("halt_set", {7'b0, sim_halt}, 8'h01);
        applyStimulus(1, 32'h0000_0010, 0, 8'h00, 0, 8'h00, 0);
        checkVal("halt_sticky", {7'b0, sim_halt}, 8'h01);

        // Stall with rdy_in low, then reset in the middle of a burst.
        applyStimulus(1, 32'h0003_0000, 1, 8'hC0, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0000, 1, 8'hC1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h0000_0010, 1, 8'h5A, 1, 8'h00, 1);
            checkVal("stall_rx_ready", {7'b0, last_rx_ready}, 8'h00);
        end
        checkVal("stall_head", uart_tx_data, 8'hC0);
        checkVal("stall_valid", {7'b0, uart_tx_valid}, 8'h01);
        applyStimulus(1, 32'h0000_0010, 0, 8'h00, 0, 8'h00, 0);
        checkVal("stall_ram_kept", bus_dout, 8'hA5);
        applyStimulus(1, 32'h0003_0000, 1, 8'hC2, 0, 8'h00, 0);
        resetMidCycle();
        applyStimulus(1, 32'h0000_0010, 0, 8'h00, 0, 8'h00, 0);
        checkVal("ram_survives_reset", bus_dout, 8'hA5);
        checkVal("halt_cleared", {7'b0, sim_halt}, 8'h00);

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            a = $urandom;
            if (r[3:0] < 4'd10) begin
                ra = r[4] ? 17'($urandom_range(0, 15)) : 17'(17'h1FFF0 + 17'($urandom_range(0, 15)));
                a[16:0] = ra;
                a[17]   = ra[16] ? 1'b0 : r[5];
            end else begin
                case (r[7:6])
                    2'd0:    a[17:0] = 18'h30000;
                    2'd1:    a[17:0] = 18'h30004;
                    2'd2:    a[17:0] = 18'h30008;
                    default: a[17:0] = 18'h3FFFF;
                endcase
                if (r[7:6] == 2'd0 && r[8]) a[17:0] = 18'h30000;
            end
            applyStimulus((r[11:9] != 3'd0), a, (r[13:12] == 2'd0 || r[14]),
                          8'($urandom), (r[16:15] == 2'd0), 8'($urandom), r[17]);
            if (n == 300) resetMidCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
